if_id_queue: RTL and testbench

//  Decoupling queue between instruction fetch and decode. It captures {PC, instruction}

---
 rtl/if_id_pkg.sv | 15 +
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 87 ++++++++
 tb/tb_if_id_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package if_id_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  // One queued fetch result.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x if_entry_t register array: one clocked write port, one async read port.
// The array is never reset; validity is tracked by the queue controller.
module if_id_queue_mem
  import if_id_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  if_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output if_entry_t       rdata
);

  if_entry_t mem [DEPTH];

  // Write the tail entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between instruction fetch and decode. Holds {pc, instr}
// pairs in FIFO order behind a valid/ready handshake; flush drops everything.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter  int unsigned     DEPTH     = 2,
  parameter  logic [XLEN-1:0] NOP_INSTR = if_id_pkg::NOP_INSTR,
  parameter  logic [XLEN-1:0] PC_INC    = if_id_pkg::PC_INC,
  localparam int unsigned     AW        = $clog2(DEPTH),
  localparam int unsigned     CW        = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  input  logic            out_ready,
  input  logic            flush,
  output logic [CW-1:0]   occupancy
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  if_entry_t     wr_entry;
  if_entry_t     head;

  // Status depends only on registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  if_id_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and count update; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Head presentation; gating on out_valid keeps stale or X storage off the outputs.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (out_valid) begin
      out_instr = head.instr;
      out_pc    = head.pc;
    end
    out_pc_plus4 = out_pc + PC_INC;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with immediate-assertion checks.
module tb_if_id_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_ready;
  logic        flush;
  logic [1:0]  occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  if_id_queue #(
    .DEPTH     (2),
    .NOP_INSTR (32'h0000_0000),
    .PC_INC    (32'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_ready    (out_ready),
    .flush        (flush),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'hxxxx_xxxx;
    in_pc     = 32'hxxxx_xxxx;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset state, with X on the idle input buses
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_occ",       {30'd0, occupancy}, 32'd0);
    chk("rst_out_instr", out_instr,          32'h0);
    chk("rst_out_pc",    out_pc,             32'h0);
    chk("rst_pc_plus4",  out_pc_plus4,       32'h4);
    step();
    reset = 1'b1;
    step();

    // Latency: no same-cycle bypass, visible one edge later
    in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'h8C22_0004;
    #1;
    chk("lat_no_bypass_valid", {31'd0, out_valid}, 32'd0);
    chk("lat_no_bypass_instr", out_instr,          32'h0);
    step();
    in_valid = 1'b0; in_pc = 32'hxxxx_xxxx; in_instr = 32'hxxxx_xxxx;
    chk("lat_valid",    {31'd0, out_valid}, 32'd1);
    chk("lat_pc",       out_pc,             32'h10);
    chk("lat_pc_plus4", out_pc_plus4,       32'h14);
    chk("lat_instr",    out_instr,          32'h8C22_0004);
    chk("lat_occ",      {30'd0, occupancy}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_drained", {30'd0, occupancy}, 32'd0);

    // Full / backpressure
    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'hA000_0000;
    step();
    chk("full_occ1",   {30'd0, occupancy}, 32'd1);
    chk("full_rdy1",   {31'd0, in_ready},  32'd1);
    in_pc = 32'h4; in_instr = 32'hA000_0001;
    step();
    chk("full_occ2",   {30'd0, occupancy}, 32'd2);
    chk("full_rdy0",   {31'd0, in_ready},  32'd0);
    in_pc = 32'h8; in_instr = 32'hA000_0002;
    step();
    chk("full_refused_occ", {30'd0, occupancy}, 32'd2);
    chk("full_head0",       out_pc,             32'h0);
    out_ready = 1'b1;
    step();
    chk("full_pop_occ",   {30'd0, occupancy}, 32'd1);
    chk("full_head4",     out_pc,             32'h4);
    chk("full_head4_ins", out_instr,          32'hA000_0001);
    chk("full_rdy_back",  {31'd0, in_ready},  32'd1);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("full_empty", {31'd0, out_valid}, 32'd0);
    chk("full_occ0",  {30'd0, occupancy}, 32'd0);

    // Streaming: one in, one out per cycle, pointers wrap repeatedly
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 32'(i * 4); in_instr = 32'h1000 + 32'(i);
      step();
      chk("stream_pc",    out_pc,             32'(i * 4));
      chk("stream_instr", out_instr,          32'h1000 + 32'(i));
      chk("stream_occ",   {30'd0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_drained", {30'd0, occupancy}, 32'd0);

    // Flush with a full queue
    in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'hB000_0040;
    step();
    in_pc = 32'h44; in_instr = 32'hB000_0044;
    step();
    chk("fl_occ2", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; in_pc = 32'h100; in_instr = 32'hC000_0100; out_ready = 1'b1;
    #1;
    chk("fl_rdy_comb", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_occ0",   {30'd0, occupancy}, 32'd0);
    chk("fl_valid0", {31'd0, out_valid}, 32'd0);
    chk("fl_pc0",    out_pc,             32'h0);

    // Flush beats a same-cycle push and pop when there is room
    in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'hC000_0200;
    step();
    chk("fl2_occ1", {30'd0, occupancy}, 32'd1);
    flush = 1'b1; in_pc = 32'h204; in_instr = 32'hC000_0204; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl2_occ0", {30'd0, occupancy}, 32'd0);

    // Re-presented push after flush appears one cycle later
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hC000_0100;
    step();
    in_valid = 1'b0;
    chk("fl_repush_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_repush_pc",    out_pc,             32'h100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // PC increment wraps modulo 2^32
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_instr = 32'hD000_0000;
    step();
    chk("wrap_pc",    out_pc,       32'hFFFF_FFFC);
    chk("wrap_plus4", out_pc_plus4, 32'h0000_0000);
    in_pc = 32'h300; in_instr = 32'hD000_0300;
    step();
    in_valid = 1'b0;
    chk("wrap_occ2", {30'd0, occupancy}, 32'd2);

    // Asynchronous reset mid-stream takes effect without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_rdy",   {31'd0, in_ready},  32'd1);
    chk("arst_occ",   {30'd0, occupancy}, 32'd0);
    chk("arst_instr", out_instr,          32'h0);
    chk("arst_plus4", out_pc_plus4,       32'h4);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_occ", {30'd0, occupancy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
